ps2_kbd_tx: RTL and testbench

PS/2 device-side transmitter: serialises keyboard scan-code bytes onto a PS/2 clock/data pair. Its output can feed the Apple-1 PS/2 receiver in place of the firmware keyboard link. It lets the core inject keystrokes itself, for example to type in a program loaded from the ARM side or to emit a reset/clear-screen scan code. A small input FIFO decouples the byte producer from the slow 10–16 kHz line timing.

---
 rtl/ps2_kbd_tx_pkg.sv | 21 ++
 rtl/ps2_kbd_tx_if.sv | 9 +
 rtl/ps2_tx_fifo.sv | 69 ++++++
 rtl/ps2_kbd_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_tx_pkg.sv
// Shared types, frame constants and parity helper for the PS/2 keyboard transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CLK_HI,
        CLK_LO,
        GAP
    } ps2_tx_state_t;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START      = 1'b0;
    localparam logic PS2_STOP       = 1'b1;

    // Odd parity: the parity bit makes the total count of ones in d+parity odd.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Byte-producer handshake into the PS/2 transmitter FIFO.
interface ps2_kbd_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO decoupling the scan-code producer from the slow PS/2 line.
module ps2_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // A full FIFO drops writes even when a pop frees a slot this cycle; flush beats push.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;

    // Next pointer/count; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: pops scan codes from a FIFO and drives 11-bit frames.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 477,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic                        clk14,
    input  logic                        rst_n,
    ps2_kbd_tx_if.slave                 tx,
    input  logic                        flush,
    output logic                        ps2_clk,
    output logic                        ps2_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // The idle window between frames also covers the IDLE pop cycle and the SETUP
    // cycle, so the GAP state itself is two cycles shorter than the line idle time.
    localparam int GAP_LEN = GAP_BITS * 2 * CLK_DIV - 2;
    localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    ps2_tx_state_t state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [10:0]      sr_q, sr_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;
    logic             busy_q, busy_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;
    logic       phase_done, last_bit, gap_done;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk   (clk14),
        .rst_n (rst_n),
        .push  (tx.tx_valid),
        .wdata (tx.tx_data),
        .pop   (fifo_pop),
        .flush (flush),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx.tx_ready = ~fifo_full;
    assign ps2_clk     = ps2_clk_q;
    assign ps2_data    = ps2_data_q;
    assign busy        = busy_q;

    assign phase_done = (div_q == DIV_W'(CLK_DIV - 1));
    assign last_bit   = (bitcnt_q == 4'(PS2_FRAME_BITS - 1));
    assign gap_done   = (gap_q == GAP_W'(GAP_LEN - 1));
    assign fifo_pop   = (state_q == IDLE) && !fifo_empty;

    // State, timing and line registers; reset aborts any frame with lines released high.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            gap_q      <= '0;
            bitcnt_q   <= '0;
            sr_q       <= '1;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            bitcnt_q   <= bitcnt_d;
            sr_q       <= sr_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state sequencing of the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SETUP;
            SETUP:   state_d = CLK_HI;
            CLK_HI:  if (phase_done) state_d = CLK_LO;
            CLK_LO:  if (phase_done) state_d = last_bit ? GAP : CLK_HI;
            GAP:     if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered line values for each state.
    always_comb begin
        div_d      = div_q;
        gap_d      = gap_q;
        bitcnt_d   = bitcnt_q;
        sr_d       = sr_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (fifo_pop) begin
                    sr_d     = {PS2_STOP, ps2_odd_parity(fifo_rdata), fifo_rdata, PS2_START};
                    bitcnt_d = '0;
                end
            end
            SETUP: begin
                ps2_data_d = sr_q[0];
                busy_d     = 1'b1;
                div_d      = '0;
            end
            CLK_HI: begin
                if (phase_done) begin
                    div_d     = '0;
                    ps2_clk_d = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            CLK_LO: begin
                if (phase_done) begin
                    div_d     = '0;
                    ps2_clk_d = 1'b1;
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (last_bit) begin
                        ps2_data_d = PS2_STOP;
                        gap_d      = '0;
                    end else begin
                        sr_d       = {1'b1, sr_q[10:1]};
                        ps2_data_d = sr_q[1];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (gap_done) busy_d = 1'b0;
                else          gap_d  = gap_q + GAP_W'(1);
            end
            default: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Randomised and directed bench for ps2_kbd_tx with a frame-timeline reference model.
module tb_ps2_kbd_tx;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int GAP_BITS   = 2;
    localparam int BIT_CYC    = 2 * CLK_DIV;
    localparam int FRAME_CYC  = 11 * BIT_CYC;
    // Offset (from the start-bit cycle) at which the transmitter is back in IDLE.
    localparam int IDLE_AT    = FRAME_CYC + 2 * GAP_BITS * CLK_DIV - 2;

    logic       clk14 = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       ps2_clk, ps2_data, busy;
    logic [3:0] fifo_count;

    ps2_kbd_tx_if bus();

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_BITS(GAP_BITS)) dut (
        .clk14      (clk14),
        .rst_n      (rst_n),
        .tx         (bus),
        .flush      (flush),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #35 clk14 = ~clk14;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned m_q[$];
    int           m_t    = -1;
    bit           m_pend = 1'b0;
    bit           m_idle = 1'b1;
    logic [10:0]  m_frame = '1;
    int           m_sz;
    bit           m_pop;
    byte unsigned m_b;

    always @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_t    = -1;
            m_pend = 1'b0;
            m_idle = 1'b1;
        end else begin
            m_sz  = m_q.size();
            m_pop = m_idle && (m_sz > 0);
            if (m_pop) m_b = m_q.pop_front();
            if (m_pend) begin
                m_t    = 0;
                m_pend = 1'b0;
            end else if (m_t >= 0) begin
                m_t++;
                if (m_t == IDLE_AT) begin
                    m_t    = -1;
                    m_idle = 1'b1;
                end
            end
            if (m_pop) begin
                m_pend  = 1'b1;
                m_idle  = 1'b0;
                m_frame = {1'b1, ~^m_b, m_b, 1'b0};
            end
            if (flush) m_q.delete();
            else if (bus.tx_valid && m_sz < FIFO_DEPTH) m_q.push_back(bus.tx_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    bit   chk_en = 1'b0;
    logic e_clk, e_dat;

    always @(negedge clk14) begin
        if (chk_en) begin
            if (m_t >= 0 && m_t < FRAME_CYC) begin
                e_clk = ((m_t % BIT_CYC) < CLK_DIV);
                e_dat = m_frame[m_t / BIT_CYC];
            end else begin
                e_clk = 1'b1;
                e_dat = 1'b1;
            end
            check("ps2_clk", 32'(ps2_clk), 32'(e_clk));
            check("ps2_data", 32'(ps2_data), 32'(e_dat));
            check("busy", 32'(busy), 32'(m_t >= 0));
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("tx_ready", 32'(bus.tx_ready), 32'(m_q.size() < FIFO_DEPTH));
        end
    end

    // ---------------- line monitors ----------------
    logic cap[$];
    always @(negedge ps2_clk) if (rst_n) cap.push_back(ps2_data);

    int   cyc = 0, last_rise = -1, peak = 0;
    int   gaps[$];
    logic prev_clk = 1'b1, prev_dat = 1'b1;
    always @(negedge clk14) begin
        cyc++;
        if (!rst_n) last_rise = -1;
        else begin
            if (ps2_clk && !prev_clk) last_rise = cyc;
            if (!ps2_data && prev_dat && ps2_clk && prev_clk && last_rise >= 0)
                gaps.push_back(cyc - last_rise);
        end
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        prev_clk = ps2_clk;
        prev_dat = ps2_data;
    end

    function automatic logic [10:0] get_frame(input int k);
        logic [10:0] f;
        for (int j = 0; j < 11; j++) f[j] = cap[k*11 + j];
        return f;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk14);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(negedge clk14);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk14);
            if (m_t < 0 && !m_pend && m_q.size() == 0) done = 1'b1;
        end
        repeat (2) @(negedge clk14);
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_caps(input int n, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk14);
            if (cap.size() >= n) done = 1'b1;
        end
        check("cap_wait", 32'(done), 32'd1);
    endtask

    logic rdy10;
    int   ncap;
    logic [7:0] rb;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        check("rst_ps2_data", 32'(ps2_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk14);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk14);

        // Single byte 0x1C
        cap.delete();
        send(8'h1C);
        wait_idle("t1_idle", 400);
        check("t1_falls", 32'(cap.size()), 32'd11);
        if (cap.size() >= 11) check("t1_bits", 32'(get_frame(0)), 32'(11'b100_0011_1000));

        // Parity: 0xF0 then 0x00
        cap.delete();
        send(8'hF0);
        wait_idle("t2a_idle", 400);
        send(8'h00);
        wait_idle("t2b_idle", 400);
        check("t2_falls", 32'(cap.size()), 32'd22);
        if (cap.size() >= 22) begin
            check("t2_f0_bits", 32'(get_frame(0)), 32'(11'b111_1110_0000));
            check("t2_00_bits", 32'(get_frame(1)), 32'(11'b110_0000_0000));
        end

        // Back-to-back frames and inter-frame gap
        cap.delete();
        gaps.delete();
        last_rise = -1;
        @(negedge clk14);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hF0;
        @(negedge clk14);
        bus.tx_data = 8'h1C;
        @(negedge clk14);
        bus.tx_valid = 1'b0;
        wait_idle("t3_idle", 600);
        check("t3_falls", 32'(cap.size()), 32'd22);
        check("t3_ngaps", 32'(gaps.size()), 32'd1);
        if (gaps.size() >= 1) check("t3_gap", 32'(gaps[0]), 32'd16);
        if (cap.size() >= 22) check("t3_second", 32'(get_frame(1)), 32'(11'b100_0011_1000));

        // FIFO full: 10 consecutive writes
        cap.delete();
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk14);
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'(8'h10 + i);
            if (i == 9) rdy10 = bus.tx_ready;
        end
        @(negedge clk14);
        bus.tx_valid = 1'b0;
        check("t4_ready_full", 32'(rdy10), 32'd0);
        wait_idle("t4_idle", 1500);
        check("t4_peak", 32'(peak), 32'd8);
        check("t4_falls", 32'(cap.size()), 32'd99);
        if (cap.size() >= 99)
            for (int k = 0; k < 9; k++) begin
                rb = 8'(8'h10 + k);
                check("t4_frame", 32'(get_frame(k)), 32'({1'b1, ~^rb, rb, 1'b0}));
            end

        // Reset during bit 5
        cap.delete();
        send(8'hA5);
        send(8'h3C);
        wait_caps(6, 400);
        @(negedge clk14);
        @(posedge clk14);
        #3 rst_n = 1'b0;
        #1;
        check("t5_clk", 32'(ps2_clk), 32'd1);
        check("t5_data", 32'(ps2_data), 32'd1);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        ncap = cap.size();
        repeat (3) @(negedge clk14);
        rst_n = 1'b1;
        repeat (300) @(negedge clk14);
        check("t5_no_edges", 32'(cap.size()), 32'(ncap));
        check("t5_falls_before", 32'(ncap), 32'd6);

        // Flush during first frame
        cap.delete();
        @(negedge clk14);
        for (int i = 0; i < 4; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'(8'h51 + i);
            @(negedge clk14);
        end
        bus.tx_valid = 1'b0;
        repeat (20) @(negedge clk14);
        flush = 1'b1;
        @(negedge clk14);
        flush = 1'b0;
        check("t6_count", 32'(fifo_count), 32'd0);
        wait_idle("t6_idle", 600);
        repeat (150) @(negedge clk14);
        check("t6_falls", 32'(cap.size()), 32'd11);

        // Randomised traffic with occasional flush (sometimes with a same-cycle push)
        for (int it = 0; it < 60; it++) begin
            @(negedge clk14);
            if ($urandom_range(0, 11) == 0) begin
                flush        = 1'b1;
                bus.tx_valid = 1'($urandom_range(0, 1));
                bus.tx_data  = 8'($urandom);
            end else begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'($urandom);
            end
            @(negedge clk14);
            flush        = 1'b0;
            bus.tx_valid = 1'b0;
            repeat ($urandom_range(0, 90)) @(negedge clk14);
        end
        wait_idle("rand_idle", 3000);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
